// File: rtl/alu_issue_ctrl_if.sv
// Handshake and ALU-side bus between the execute-stage issue controller and its
// neighbours: instruction source, ALU and register-file writeback.
interface alu_issue_ctrl_if #(
  parameter int XLEN = 32
);
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic            alu_en;
  logic            alu_r;
  logic            alu_i;
  logic [XLEN-1:0] alu_imm;
  logic [3:0]      alu_opcode;
  logic [XLEN-1:0] alu_result;
  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_we;
  logic            illegal;

  modport master (
    output instr_valid, instr, alu_result, wb_ready,
    input  instr_ready, rs1_addr, rs2_addr, alu_en, alu_r, alu_i, alu_imm,
           alu_opcode, wb_valid, wb_rd, wb_data, wb_we, illegal
  );

  modport slave (
    input  instr_valid, instr, alu_result, wb_ready,
    output instr_ready, rs1_addr, rs2_addr, alu_en, alu_r, alu_i, alu_imm,
           alu_opcode, wb_valid, wb_rd, wb_data, wb_we, illegal
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Execute-stage front end: decodes RV32I OP/OP-IMM, pulses the ALU enable, waits a
// fixed latency for the result and hands it to writeback over valid/ready.
module alu_issue_ctrl #(
  parameter int RESULT_LATENCY = 1,
  parameter int XLEN           = 32
) (
  input logic             clk,
  input logic             rst,
  alu_issue_ctrl_if.slave bus
);
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic            alu_r_q, alu_r_d, alu_i_q, alu_i_d;
  logic            we_q, we_d, illegal_q, illegal_d;
  logic [3:0]      opc_q, opc_d;
  logic [XLEN-1:0] imm_q, imm_d, data_q, data_d;

  logic [6:0]      op, f7;
  logic [2:0]      f3;
  logic            dec_legal, dec_r, accept;
  logic [3:0]      dec_opc;
  logic [XLEN-1:0] dec_imm;

  assign op     = bus.instr[6:0];
  assign f3     = bus.instr[14:12];
  assign f7     = bus.instr[31:25];
  assign accept = bus.instr_valid && (state_q == IDLE);

  // Shift immediates carry funct7 in the upper bits, so only the shamt is passed on.
  always_comb begin
    dec_legal = 1'b0;
    dec_r     = 1'b0;
    dec_opc   = {f3, 1'b0};
    dec_imm   = '0;
    if (op == OPC_OP) begin
      dec_r     = 1'b1;
      dec_opc   = {f3, bus.instr[30]};
      dec_legal = (f7 == 7'b0000000) ||
                  ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
    end else if (op == OPC_OPIMM) begin
      case (f3)
        3'b001: begin
          dec_legal = (f7 == 7'b0000000);
          dec_imm   = {{(XLEN-5){1'b0}}, bus.instr[24:20]};
        end
        3'b101: begin
          dec_legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          dec_imm   = {{(XLEN-5){1'b0}}, bus.instr[24:20]};
          dec_opc   = {f3, bus.instr[30]};
        end
        default: begin
          dec_legal = 1'b1;
          dec_imm   = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
        end
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    alu_r_d   = alu_r_q;
    alu_i_d   = alu_i_q;
    we_d      = we_q;
    opc_d     = opc_q;
    imm_d     = imm_q;
    data_d    = data_q;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (dec_legal) begin
            state_d = ISSUE;
            rs1_d   = bus.instr[19:15];
            rs2_d   = bus.instr[24:20];
            rd_d    = bus.instr[11:7];
            we_d    = (bus.instr[11:7] != 5'd0);
            alu_r_d = dec_r;
            alu_i_d = ~dec_r;
            opc_d   = dec_opc;
            imm_d   = dec_imm;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = 3'(RESULT_LATENCY);
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        // The counter reaches zero on this edge: the ALU result is due now.
        if (cnt_q <= 3'd1) begin
          cnt_d   = 3'd0;
          data_d  = bus.alu_result;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      alu_r_q   <= 1'b0;
      alu_i_q   <= 1'b0;
      we_q      <= 1'b0;
      opc_q     <= '0;
      imm_q     <= '0;
      data_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      alu_r_q   <= alu_r_d;
      alu_i_q   <= alu_i_d;
      we_q      <= we_d;
      opc_q     <= opc_d;
      imm_q     <= imm_d;
      data_q    <= data_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.instr_ready = (state_q == IDLE);
  assign bus.alu_en      = (state_q == ISSUE);
  assign bus.wb_valid    = (state_q == RESP);
  assign bus.rs1_addr    = rs1_q;
  assign bus.rs2_addr    = rs2_q;
  assign bus.alu_r       = alu_r_q;
  assign bus.alu_i       = alu_i_q;
  assign bus.alu_imm     = imm_q;
  assign bus.alu_opcode  = opc_q;
  assign bus.wb_rd       = rd_q;
  assign bus.wb_data     = data_q;
  assign bus.wb_we       = we_q;
  assign bus.illegal     = illegal_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed vector table, reset-abort sequence and
// randomized instructions checked against a mnemonic-level reference decoder.
module tb_alu_issue_ctrl;
  localparam int L    = 3;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.XLEN(XLEN)) bus ();
  alu_issue_ctrl #(.RESULT_LATENCY(L), .XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        legal;
    logic [3:0]  opc;
    logic        r;
    logic [31:0] imm;
  } dec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] res;
    logic        legal;
    logic [3:0]  opc;
    logic        r;
    logic [31:0] imm;
    int          hold;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference decoder: mnemonic lookup on {funct7, funct3}, not field arithmetic.
  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t        d;
    logic [9:0]  key;
    logic [31:0] simm;
    key  = {w[31:25], w[14:12]};
    simm = 32'($signed(w[31:20]));
    d.legal = 1'b0; d.opc = 4'h0; d.r = 1'b0; d.imm = 32'h0;
    if (w[6:0] == 7'b0110011) begin
      d.r = 1'b1; d.legal = 1'b1;
      case (key)
        {7'h00, 3'd0}: d.opc = 4'b0000;  // ADD
        {7'h20, 3'd0}: d.opc = 4'b0001;  // SUB
        {7'h00, 3'd1}: d.opc = 4'b0010;  // SLL
        {7'h00, 3'd2}: d.opc = 4'b0100;  // SLT
        {7'h00, 3'd3}: d.opc = 4'b0110;  // SLTU
        {7'h00, 3'd4}: d.opc = 4'b1000;  // XOR
        {7'h00, 3'd5}: d.opc = 4'b1010;  // SRL
        {7'h20, 3'd5}: d.opc = 4'b1011;  // SRA
        {7'h00, 3'd6}: d.opc = 4'b1100;  // OR
        {7'h00, 3'd7}: d.opc = 4'b1110;  // AND
        default:       d.legal = 1'b0;
      endcase
    end else if (w[6:0] == 7'b0010011) begin
      d.legal = 1'b1; d.imm = simm;
      case (w[14:12])
        3'd0: d.opc = 4'b0000;
        3'd2: d.opc = 4'b0100;
        3'd3: d.opc = 4'b0110;
        3'd4: d.opc = 4'b1000;
        3'd6: d.opc = 4'b1100;
        3'd7: d.opc = 4'b1110;
        3'd1: begin
          d.opc = 4'b0010; d.imm = {27'd0, w[24:20]};
          d.legal = (w[31:25] == 7'h00);
        end
        default: begin
          d.imm = {27'd0, w[24:20]};
          if (w[31:25] == 7'h00)      d.opc = 4'b1010;
          else if (w[31:25] == 7'h20) d.opc = 4'b1011;
          else                        d.legal = 1'b0;
        end
      endcase
    end
    return d;
  endfunction

  task automatic do_instr(input logic [31:0] w, input logic [31:0] res, input logic legal,
                          input logic [3:0] opc, input logic r, input logic [31:0] imm,
                          input int hold);
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    bus.wb_ready    = 1'b0;
    bus.alu_result  = ~res;
    chk("ready_before_accept", 32'(bus.instr_ready), 32'd1);
    step();
    bus.instr_valid = 1'b0;
    if (!legal) begin
      chk("illegal_pulse", {bus.illegal, bus.alu_en, bus.instr_ready, bus.wb_valid}, 32'b1010);
      step();
      chk("illegal_after", {bus.illegal, bus.alu_en, bus.instr_ready, bus.wb_valid}, 32'b0010);
      return;
    end
    chk("issue_ctrl", {bus.alu_en, bus.alu_r, bus.alu_i, bus.illegal, bus.instr_ready},
        {27'd0, 1'b1, r, ~r, 1'b0, 1'b0});
    chk("issue_opcode", 32'(bus.alu_opcode), 32'(opc));
    chk("issue_imm", bus.alu_imm, imm);
    chk("issue_rs", {bus.rs1_addr, bus.rs2_addr}, {22'd0, w[19:15], w[24:20]});
    // A new instruction offered while busy must be ignored.
    bus.instr       = $urandom;
    bus.instr_valid = 1'b1;
    for (int k = 1; k <= L + 1; k++) begin
      step();
      bus.alu_result = (k == L) ? res : ~res;
      if (k <= L) begin
        chk("wait_quiet", {bus.alu_en, bus.wb_valid, bus.instr_ready}, 32'b000);
        chk("wait_hold_opc", 32'(bus.alu_opcode), 32'(opc));
      end else begin
        chk("wb_valid", {bus.wb_valid, bus.instr_ready, bus.alu_en}, 32'b100);
        chk("wb_rd_we", {bus.wb_rd, bus.wb_we}, {26'd0, w[11:7], (w[11:7] != 5'd0)});
        chk("wb_data", bus.wb_data, res);
      end
    end
    for (int h = 0; h < hold; h++) begin
      step();
      chk("resp_hold", {bus.wb_valid, bus.instr_ready}, 32'b10);
      chk("resp_hold_data", bus.wb_data, res);
    end
    bus.wb_ready = 1'b1;
    step();
    bus.wb_ready    = 1'b0;
    bus.instr_valid = 1'b0;
    chk("resp_done", {bus.wb_valid, bus.instr_ready, bus.alu_en}, 32'b010);
  endtask

  initial begin
    logic [31:0] w;
    dec_t        d;
    int          sel;

    tbl[0]  = '{32'h002081B3, 32'h00000007, 1'b1, 4'b0000, 1'b1, 32'h00000000, 0};  // ADD x3,x1,x2
    tbl[1]  = '{32'h402081B3, 32'hDEADBEEF, 1'b1, 4'b0001, 1'b1, 32'h00000000, 5};  // SUB
    tbl[2]  = '{32'hFFF00293, 32'hFFFFFFFF, 1'b1, 4'b0000, 1'b0, 32'hFFFFFFFF, 1};  // ADDI x5,x0,-1
    tbl[3]  = '{32'h40000093, 32'h00000400, 1'b1, 4'b0000, 1'b0, 32'h00000400, 0};  // ADDI x1,x0,1024
    tbl[4]  = '{32'h4042D313, 32'h12345678, 1'b1, 4'b1011, 1'b0, 32'h00000004, 2};  // SRAI x6,x5,4
    tbl[5]  = '{32'h40429313, 32'h0,        1'b0, 4'b0000, 1'b0, 32'h0,        0};  // SLLI f7=0100000
    tbl[6]  = '{32'h0000006F, 32'h0,        1'b0, 4'b0000, 1'b0, 32'h0,        0};  // JAL
    tbl[7]  = '{32'h00208033, 32'hA5A5A5A5, 1'b1, 4'b0000, 1'b1, 32'h00000000, 0};  // ADD x0,x1,x2
    tbl[8]  = '{32'h4020D1B3, 32'h80000000, 1'b1, 4'b1011, 1'b1, 32'h00000000, 0};  // SRA
    tbl[9]  = '{32'h0020F1B3, 32'h0000FFFF, 1'b1, 4'b1110, 1'b1, 32'h00000000, 1};  // AND
    tbl[10] = '{32'h402091B3, 32'h0,        1'b0, 4'b0000, 1'b0, 32'h0,        0};  // SLL f7=0100000
    tbl[11] = '{32'h022081B3, 32'h0,        1'b0, 4'b0000, 1'b0, 32'h0,        0};  // MUL encoding

    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.wb_ready    = 1'b0;
    bus.alu_result  = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("reset_ctrl", {bus.instr_ready, bus.alu_en, bus.wb_valid, bus.illegal,
                       bus.alu_r, bus.alu_i, bus.wb_we}, 32'b1000000);
    chk("reset_data", bus.alu_imm | bus.wb_data | 32'(bus.alu_opcode) |
                      32'({bus.rs1_addr, bus.rs2_addr, bus.wb_rd}), 32'd0);

    for (int i = 0; i < 12; i++)
      do_instr(tbl[i].instr, tbl[i].res, tbl[i].legal, tbl[i].opc, tbl[i].r, tbl[i].imm, tbl[i].hold);

    // Reset while waiting for the ALU result aborts the operation.
    bus.instr       = 32'h002081B3;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_wait_ctrl", {bus.instr_ready, bus.wb_valid, bus.alu_en, bus.alu_r}, 32'b1000);
    chk("rst_wait_opc", 32'(bus.alu_opcode), 32'd0);
    for (int k = 0; k < L + 3; k++) begin
      step();
      chk("rst_wait_quiet", {bus.instr_ready, bus.wb_valid, bus.alu_en}, 32'b100);
    end
    do_instr(32'h002081B3, 32'h00000007, 1'b1, 4'b0000, 1'b1, 32'h0, 0);

    for (int n = 0; n < 150; n++) begin
      w   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 4)      w[6:0] = 7'b0110011;
      else if (sel < 8) w[6:0] = 7'b0010011;
      if (sel < 8) begin
        case ($urandom_range(0, 3))
          0, 1:    w[31:25] = 7'h00;
          2:       w[31:25] = 7'h20;
          default: ;
        endcase
      end
      d = ref_decode(w);
      do_instr(w, $urandom, d.legal, d.opc, d.r, d.imm, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
